// File: rtl/xeng_cmac_acc.sv
// Double-buffered complex accumulator at the tail of the DSP48E CMAC chain.
// Define XENG_CMAC_ACC_SAT_EN for saturating adds (adds one input pipeline stage).
module xeng_cmac_acc #(
   parameter int unsigned IN_WIDTH  = 12,
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned N_BL_BITS = 4,
   parameter int unsigned ACC_LEN   = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2*IN_WIDTH-1:0]    din,
   input  logic                     din_valid,
   input  logic                     sync,
   output logic [2*ACC_WIDTH-1:0]   dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     dout_last,
   output logic                     dump_dropped,
   output logic                     sync_err
);

   localparam int unsigned N_BL = 1 << N_BL_BITS;
   localparam int unsigned VC_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam int unsigned AD_W = N_BL_BITS + 1;

   typedef enum logic {
      A_WAIT_SYNC,
      A_ACC
   } acc_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_LOAD,
      R_DRAIN
   } rd_state_t;

   acc_state_t             a_state, a_state_n;
   rd_state_t              r_state, r_state_n;

   logic                   in_valid;
   logic                   in_sync;
   logic [2*IN_WIDTH-1:0]  in_data;

   logic [N_BL_BITS-1:0]   idx, idx_n, eff_idx;
   logic [VC_W-1:0]        vcnt, vcnt_n, eff_vcnt;
   logic                   wb, wb_n;
   logic                   we;
   logic                   handover;
   logic                   set_drop;
   logic                   set_sync_err;
   logic                   bank_free;
   logic [ACC_WIDTH-1:0]   ext_re, ext_im;
   logic [ACC_WIDTH-1:0]   wr_re, wr_im;

   logic [N_BL_BITS-1:0]   rd_idx, rd_idx_n;
   logic                   load;
   logic                   clear;

   // Bank storage indexed by {bank, baseline}; contents need no reset.
   logic [ACC_WIDTH-1:0]   acc_re [2*N_BL];
   logic [ACC_WIDTH-1:0]   acc_im [2*N_BL];

   function automatic logic [ACC_WIDTH-1:0] add_part(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [ACC_WIDTH-1:0] b);
`ifdef XENG_CMAC_ACC_SAT_EN
      logic [ACC_WIDTH:0] s;
      s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
         add_part = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
         add_part = s[ACC_WIDTH-1:0];
      end
`else
      add_part = a + b;
`endif
   endfunction

`ifdef XENG_CMAC_ACC_SAT_EN
   // Extra input register gives the saturating adder a full cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_valid <= 1'b0;
         in_sync  <= 1'b0;
         in_data  <= '0;
      end else begin
         in_valid <= din_valid;
         in_sync  <= sync;
         in_data  <= din;
      end
   end
`else
   always_comb begin
      in_valid = din_valid;
      in_sync  = sync;
      in_data  = din;
   end
`endif

   always_comb begin
      ext_re = ACC_WIDTH'($signed(in_data[2*IN_WIDTH-1:IN_WIDTH]));
      ext_im = ACC_WIDTH'($signed(in_data[IN_WIDTH-1:0]));
   end

   // Readout bank is free when idle or when its final beat leaves this cycle.
   assign bank_free = (r_state == R_IDLE) ||
                      ((r_state == R_DRAIN) && dout_ready && dout_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_state <= A_WAIT_SYNC;
         idx     <= '0;
         vcnt    <= '0;
         wb      <= 1'b0;
      end else begin
         a_state <= a_state_n;
         idx     <= idx_n;
         vcnt    <= vcnt_n;
         wb      <= wb_n;
      end
   end

   always_comb begin
      a_state_n    = a_state;
      idx_n        = idx;
      vcnt_n       = vcnt;
      wb_n         = wb;
      we           = 1'b0;
      eff_idx      = idx;
      eff_vcnt     = vcnt;
      set_sync_err = 1'b0;
      set_drop     = 1'b0;
      handover     = 1'b0;
      wr_re        = '0;
      wr_im        = '0;

      if (in_valid) begin
         case (a_state)
            A_WAIT_SYNC: begin
               if (in_sync) begin
                  we        = 1'b1;
                  eff_idx   = '0;
                  eff_vcnt  = '0;
                  a_state_n = A_ACC;
               end
            end
            default: begin
               we = 1'b1;
               // Misplaced sync restarts the integration from this beat.
               if (in_sync && (idx != '0)) begin
                  set_sync_err = 1'b1;
                  eff_idx      = '0;
                  eff_vcnt     = '0;
               end
            end
         endcase
      end

      if (we) begin
         if (eff_vcnt == '0) begin
            wr_re = ext_re;
            wr_im = ext_im;
         end else begin
            wr_re = add_part(acc_re[{wb, eff_idx}], ext_re);
            wr_im = add_part(acc_im[{wb, eff_idx}], ext_im);
         end

         if (eff_idx == N_BL_BITS'(N_BL - 1)) begin
            idx_n = '0;
            if (eff_vcnt == VC_W'(ACC_LEN - 1)) begin
               vcnt_n = '0;
               if (bank_free) begin
                  handover = 1'b1;
                  wb_n     = ~wb;
               end else begin
                  set_drop = 1'b1;
               end
            end else begin
               vcnt_n = VC_W'(eff_vcnt + 1'b1);
            end
         end else begin
            idx_n  = N_BL_BITS'(eff_idx + 1'b1);
            vcnt_n = eff_vcnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         acc_re[{wb, eff_idx}] <= wr_re;
         acc_im[{wb, eff_idx}] <= wr_im;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= R_IDLE;
         rd_idx  <= '0;
      end else begin
         r_state <= r_state_n;
         rd_idx  <= rd_idx_n;
      end
   end

   always_comb begin
      r_state_n = r_state;
      rd_idx_n  = rd_idx;
      load      = 1'b0;
      clear     = 1'b0;

      case (r_state)
         R_IDLE: begin
            if (handover) begin
               r_state_n = R_LOAD;
               rd_idx_n  = '0;
            end
         end
         R_LOAD: begin
            load      = 1'b1;
            r_state_n = R_DRAIN;
         end
         R_DRAIN: begin
            if (dout_ready) begin
               if (dout_last) begin
                  clear = 1'b1;
                  if (handover) begin
                     r_state_n = R_LOAD;
                     rd_idx_n  = '0;
                  end else begin
                     r_state_n = R_IDLE;
                  end
               end else begin
                  load = 1'b1;
               end
            end
         end
         default: r_state_n = R_IDLE;
      endcase

      if (load) begin
         rd_idx_n = N_BL_BITS'(rd_idx + 1'b1);
      end
   end

   // The readout bank is always the one not being written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout         <= '0;
         dout_valid   <= 1'b0;
         dout_last    <= 1'b0;
         dump_dropped <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         if (load) begin
            dout       <= {acc_re[{~wb, rd_idx}], acc_im[{~wb, rd_idx}]};
            dout_valid <= 1'b1;
            dout_last  <= (rd_idx == N_BL_BITS'(N_BL - 1));
         end else if (clear) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
         end
         if (set_drop) begin
            dump_dropped <= 1'b1;
         end
         if (set_sync_err) begin
            sync_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_xeng_cmac_acc.sv
// Directed bench for xeng_cmac_acc: 4 baselines, 4-vector integrations,
// plus a 12-bit accumulator instance for the overflow case.
module tb_xeng_cmac_acc;

   localparam int IW  = 12;
   localparam int AW  = 16;
   localparam int OW  = 12;
   localparam int NB  = 2;
   localparam int NBL = 1 << NB;
   localparam int AL  = 4;
`ifdef XENG_CMAC_ACC_SAT_EN
   localparam int LAT = 3;
   localparam bit SAT = 1'b1;
`else
   localparam int LAT = 2;
   localparam bit SAT = 1'b0;
`endif
   localparam int SH = LAT - 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [2*IW-1:0] din;
   logic            din_valid, sync;
   logic [2*AW-1:0] dout;
   logic            dout_valid, dout_ready, dout_last, dump_dropped, sync_err;

   logic [2*IW-1:0] o_din;
   logic            o_din_valid, o_sync;
   logic [2*OW-1:0] o_dout;
   logic            o_dout_valid, o_dout_ready, o_dout_last, o_dump_dropped, o_sync_err;

   int n_vec = 0;
   int n_err = 0;

   xeng_cmac_acc #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .N_BL_BITS(NB), .ACC_LEN(AL)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last), .dump_dropped(dump_dropped), .sync_err(sync_err)
   );

   xeng_cmac_acc #(.IN_WIDTH(IW), .ACC_WIDTH(OW), .N_BL_BITS(NB), .ACC_LEN(AL)) dut_ovf (
      .clk(clk), .rst(rst), .din(o_din), .din_valid(o_din_valid), .sync(o_sync),
      .dout(o_dout), .dout_valid(o_dout_valid), .dout_ready(o_dout_ready),
      .dout_last(o_dout_last), .dump_dropped(o_dump_dropped), .sync_err(o_sync_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int re, input int im, input bit s);
      din       = {IW'(re), IW'(im)};
      din_valid = 1'b1;
      sync      = s;
      step();
      din_valid = 1'b0;
      sync      = 1'b0;
   endtask

   task automatic send_int(input int kr, input int cr, input int ki, input int ci);
      for (int v = 0; v < AL; v++)
         for (int b = 0; b < NBL; b++)
            beat(kr * b + cr, ki * b + ci, (v == 0) && (b == 0));
   endtask

   function automatic logic [2*AW-1:0] exp_word(input int kr, input int cr,
                                                input int ki, input int ci, input int b);
      int r, i;
      r = AL * (kr * b + cr);
      i = AL * (ki * b + ci);
      return {AW'(r), AW'(i)};
   endfunction

   task automatic test_reset;
      rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0; dout_ready = 1'b0;
      o_din = '0; o_din_valid = 1'b0; o_sync = 1'b0; o_dout_ready = 1'b1;
      repeat (3) step();
      n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
      n_vec++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout got %h exp 0", dout); end
      n_vec++; if (dout_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b exp 0", dout_last); end
      n_vec++; if (dump_dropped !== 1'b0 || sync_err !== 1'b0) begin
         n_err++; $display("FAIL reset_flags got %b%b exp 00", dump_dropped, sync_err);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single;
      logic [2*AW-1:0] e;
      dout_ready = 1'b1;
      send_int(1, 1, -1, -1);
      for (int k = 0; k < LAT - 1; k++) begin
         n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL single_early k=%0d got %b exp 0", k, dout_valid); end
         step();
      end
      for (int b = 0; b < NBL; b++) begin
         e = exp_word(1, 1, -1, -1, b);
         n_vec++;
         if (dout_valid !== 1'b1 || dout !== e || dout_last !== (b == NBL - 1)) begin
            n_err++; $display("FAIL single_beat%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                              b, dout_valid, dout, dout_last, e, b == NBL - 1);
         end
         step();
      end
      n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL single_end got %b exp 0", dout_valid); end
   endtask

   task automatic test_backpressure;
      logic [2*AW-1:0] e;
      int got;
      dout_ready = 1'b0;
      send_int(3, 2, 1, 0);
      repeat (LAT - 1) step();
      got = 0;
      for (int cyc = 0; cyc < 20 && got < NBL; cyc++) begin
         dout_ready = (cyc % 2 == 0);
         e = exp_word(3, 2, 1, 0, got);
         n_vec++;
         if (dout_valid !== 1'b1 || dout !== e || dout_last !== (got == NBL - 1)) begin
            n_err++; $display("FAIL bp_beat%0d cyc=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                              got, cyc, dout_valid, dout, dout_last, e, got == NBL - 1);
         end
         if (dout_ready) got++;
         step();
      end
      n_vec++; if (got !== NBL) begin n_err++; $display("FAIL bp_count got %0d exp %0d", got, NBL); end
      dout_ready = 1'b1;
      n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra got %b exp 0", dout_valid); end
   endtask

   task automatic test_dropped;
      logic [2*AW-1:0] e;
      dout_ready = 1'b0;
      send_int(1, 1, 0, 1);
      repeat (LAT) step();
      n_vec++; if (dump_dropped !== 1'b0) begin n_err++; $display("FAIL drop_early got %b exp 0", dump_dropped); end
      send_int(0, 100, 0, -1);
      repeat (LAT) step();
      n_vec++; if (dump_dropped !== 1'b1) begin n_err++; $display("FAIL drop_flag got %b exp 1", dump_dropped); end
      dout_ready = 1'b1;
      for (int b = 0; b < NBL; b++) begin
         e = exp_word(1, 1, 0, 1, b);
         n_vec++;
         if (dout_valid !== 1'b1 || dout !== e || dout_last !== (b == NBL - 1)) begin
            n_err++; $display("FAIL drop_beat%0d got v=%b d=%h exp v=1 d=%h", b, dout_valid, dout, e);
         end
         step();
      end
      repeat (3) step();
      n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL drop_second_dump got %b exp 0", dout_valid); end
   endtask

   task automatic test_resync;
      logic [2*AW-1:0] e;
      dout_ready = 1'b1;
      n_vec++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL resync_pre got %b exp 0", sync_err); end
      for (int k = 0; k < NBL + 2; k++) beat(500, 500, k == 0);
      send_int(1, 1, 2, 0);
      repeat (LAT - 1) step();
      n_vec++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL resync_flag got %b exp 1", sync_err); end
      for (int b = 0; b < NBL; b++) begin
         e = exp_word(1, 1, 2, 0, b);
         n_vec++;
         if (dout_valid !== 1'b1 || dout !== e || dout_last !== (b == NBL - 1)) begin
            n_err++; $display("FAIL resync_beat%0d got v=%b d=%h exp v=1 d=%h", b, dout_valid, dout, e);
         end
         step();
      end
      n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL resync_end got %b exp 0", dout_valid); end
   endtask

   task automatic test_overflow;
      logic [2*OW-1:0] e;
      e = SAT ? {12'h7FF, 12'h800} : {12'hFFC, 12'h000};
      o_dout_ready = 1'b1;
      for (int k = 0; k < NBL * AL; k++) begin
         o_din = {12'h7FF, 12'h800}; o_din_valid = 1'b1; o_sync = (k == 0);
         step();
      end
      o_din_valid = 1'b0; o_sync = 1'b0;
      repeat (LAT - 1) step();
      for (int b = 0; b < NBL; b++) begin
         n_vec++;
         if (o_dout_valid !== 1'b1 || o_dout !== e || o_dout_last !== (b == NBL - 1)) begin
            n_err++; $display("FAIL ovf_beat%0d got v=%b d=%h exp v=1 d=%h", b, o_dout_valid, o_dout, e);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_drain;
      logic [2*AW-1:0] e;
      bit seen;
      dout_ready = 1'b1;
      send_int(2, 0, 0, 3);
      repeat (LAT - 1) step();
      e = exp_word(2, 0, 0, 3, 0);
      n_vec++; if (dout_valid !== 1'b1 || dout !== e) begin n_err++; $display("FAIL rmd_beat0 got v=%b d=%h exp v=1 d=%h", dout_valid, dout, e); end
      step();
      rst = 1'b1;
      #1;
      n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rmd_valid got %b exp 0", dout_valid); end
      n_vec++; if (dump_dropped !== 1'b0 || sync_err !== 1'b0) begin
         n_err++; $display("FAIL rmd_flags got %b%b exp 00", dump_dropped, sync_err);
      end
      step();
      rst = 1'b0;
      step();
      seen = 1'b0;
      for (int k = 0; k < 2 * NBL * AL; k++) begin
         beat(7, 7, 1'b0);
         seen = seen | dout_valid;
      end
      repeat (6) begin step(); seen = seen | dout_valid; end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmd_nosync got %b exp 0", seen); end
      send_int(1, 0, -1, 0);
      repeat (LAT - 1) step();
      for (int b = 0; b < NBL; b++) begin
         e = exp_word(1, 0, -1, 0, b);
         n_vec++;
         if (dout_valid !== 1'b1 || dout !== e || dout_last !== (b == NBL - 1)) begin
            n_err++; $display("FAIL rmd_beat%0d got v=%b d=%h exp v=1 d=%h", b, dout_valid, dout, e);
         end
         step();
      end
   endtask

   task automatic test_back_to_back;
      logic [2*AW-1:0] e;
      dout_ready = 1'b0;
      send_int(1, 2, 0, 0);
      // Last readout beat of X leaves on the same cycle Y completes.
      for (int j = 0; j <= 15 + SH; j++) begin
         dout_ready = ((j >= 1 + SH) && (j <= 3 + SH)) || (j == 15 + SH);
         if (j == 15 + SH) begin
            e = exp_word(1, 2, 0, 0, NBL - 1);
            n_vec++;
            if (dout_valid !== 1'b1 || dout_last !== 1'b1 || dout !== e) begin
               n_err++; $display("FAIL b2b_xlast got v=%b l=%b d=%h exp v=1 l=1 d=%h", dout_valid, dout_last, dout, e);
            end
         end
         if (j < NBL * AL) beat(0 * (j % NBL) + 5, (j % NBL) + 1, j == 0);
         else step();
      end
      dout_ready = 1'b1;
      n_vec++; if (dump_dropped !== 1'b0) begin n_err++; $display("FAIL b2b_drop got %b exp 0", dump_dropped); end
      n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap got %b exp 0", dout_valid); end
      step();
      for (int b = 0; b < NBL; b++) begin
         e = exp_word(0, 5, 1, 1, b);
         n_vec++;
         if (dout_valid !== 1'b1 || dout !== e || dout_last !== (b == NBL - 1)) begin
            n_err++; $display("FAIL b2b_ybeat%0d got v=%b d=%h exp v=1 d=%h", b, dout_valid, dout, e);
         end
         step();
      end
      n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b exp 0", dout_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_dropped();
      test_resync();
      test_overflow();
      test_reset_mid_drain();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/xeng_cmac_acc.md
Name: xeng_cmac_acc

Overview:
- Consumer end of the DSP48E complex MAC chain.
- Takes the chain's registered packed complex product stream {real, imag}, one baseline per valid beat, and sign-extends each part.
- Accumulates each baseline over ACC_LEN vectors in a double-buffered accumulator bank.
- Drains each completed integration through a valid/ready output port while the next integration accumulates.

Parameters:
- IN_WIDTH, 12: width of each real/imag input part (2*BITWIDTH+1+N_INPUT_BITS of the chain); two's complement.
- ACC_WIDTH, 32: width of each real/imag accumulator part.
- N_BL_BITS, 4: log2 of baselines per vector; N_BL = 1<<N_BL_BITS.
- ACC_LEN, 64: vectors per integration; >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  2*IN_WIDTH  {real[2*IN_WIDTH-1:IN_WIDTH], imag[IN_WIDTH-1:0]}.
- din_valid  in  1  din carries one baseline this cycle.
- sync  in  1  qualified by din_valid; marks baseline 0 of a vector.
- dout  out  2*ACC_WIDTH  {acc_real, acc_imag}.
- dout_valid  out  1  dout holds a valid accumulated baseline.
- dout_ready  in  1  downstream accepts dout.
- dout_last  out  1  dout is baseline N_BL-1 of the dump.
- dump_dropped  out  1  sticky: a completed integration was discarded.
- sync_err  out  1  sticky: sync seen at a nonzero baseline index.

Behaviour:
- Reset (async): all outputs 0; write bank 0; baseline idx 0; vector count 0; accumulation FSM in WAIT_SYNC; readout FSM in IDLE. Accumulator contents are don't-care.
- Accumulation FSM:
  - WAIT_SYNC: din beats are ignored until din_valid&&sync, then go to ACC, processing that beat as baseline 0 of vector 0.
  - ACC: each din_valid beat targets baseline idx, then idx increments.
    - Vector count 0: acc[idx] = sext(din).
    - Otherwise: acc[idx] += sext(din), real and imag independent.
  - Wrap: at idx N_BL-1, idx wraps to 0 and the vector count increments.
  - End of integration: when the vector count reaches ACC_LEN on that wrap, the write bank completes, the vector count resets to 0, and banks swap if the readout bank is free.
  - Bank busy at completion: the completed bank is discarded (not swapped), dump_dropped is set, and the next integration overwrites the same bank starting at vector count 0.
  - sync at idx != 0: sync_err is set; the beat is taken as baseline 0, the vector count restarts at 0, and the partial integration is discarded.
  - sync at idx 0: normal, no effect.
- Readout FSM:
  - IDLE -> DRAIN when a bank is handed over.
  - DRAIN: presents baselines 0..N_BL-1 in order. A beat transfers when dout_valid&&dout_ready.
  - dout and dout_last hold stable while dout_valid && !dout_ready.
  - After the last transfer: back to IDLE, bank freed.
- Latency: dout_valid rises 2 cycles after the din_valid beat that completes an integration.
- Throughput: with dout_ready held high, back-to-back beats, one per cycle.
- Simultaneous events:
  - A bank completing on the same cycle the readout transfers its last beat counts as free: swap, no drop.
  - din_valid while dout is stalled is always accepted; there is no input backpressure.
- ACC_LEN == 1: every vector is a dump.
- Arithmetic: inputs are sign-extended from IN_WIDTH to ACC_WIDTH. Default overflow behaviour is two's complement wrap.

Optional Feature:
- Macro XENG_CMAC_ACC_SAT_EN.
- Defined: each real/imag add saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; an extra 1-cycle pipeline stage is added, so dout_valid latency becomes 3.
- Undefined: modular wrap, latency 2.

Test Plan (N_BL_BITS=2, ACC_LEN=4, IN_WIDTH=12, ACC_WIDTH=16 unless stated):
- Single integration: sync, then 16 beats with real=b+1, imag=-(b+1) for baseline b, dout_ready=1 -> dout sequence real=4,8,12,16 and imag=-4,-8,-12,-16; dout_last only on the 4th beat; dout_valid 2 cycles after the last input.
- Backpressure: dout_ready toggles 1010... -> dout stable while stalled; all 4 beats delivered exactly once, in order.
- Dropped dump: dout_ready=0 through two full integrations -> dump_dropped=1; the first dump delivered after release holds the first integration's values.
- Resync: sync asserted at idx 2 mid-integration -> sync_err=1; the next dump equals 4 vectors counted from the new sync.
- Overflow with ACC_WIDTH=12, ACC_LEN=4, real=2047:
  - Macro undefined: real=-4 (wrap of 8188).
  - Macro defined: real=2047.
- Reset mid-drain: rst asserted during the 2nd dout beat -> dout_valid=0 immediately; sticky flags cleared; din ignored until the next sync.
